// File: rtl/msrv_32_pkg.sv
// Shared types and constants for the msrv_32 instruction-fetch slice.
package msrv_32_pkg;

    localparam logic [1:0]  HTRANS_IDLE       = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ     = 2'b10;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } buf_entry_t;

endpackage

// File: rtl/msrv_32_instr_buf.sv
// Small shift-style FIFO holding fetched {instr, pc} entries; entry 0 is the head.
module msrv_32_instr_buf
    import msrv_32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  buf_entry_t       push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output buf_entry_t       head_o,
    output logic             valid_o
);

    buf_entry_t       mem_q [DEPTH];
    buf_entry_t       mem_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_pop_s;
    int               wr_idx_s;

    // Next-state: flush wins, otherwise shift on pop and write behind the survivors.
    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        do_pop_s = pop_i && (cnt_q != '0);
        wr_idx_s = int'(cnt_q) - (do_pop_s ? 1 : 0);
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            if (do_pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end else begin
                mem_d = mem_q;
            end
            if (push_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == wr_idx_s) begin
                        mem_d[i] = push_data_i;
                    end else begin
                        mem_d[i] = mem_d[i];
                    end
                end
            end else begin
                mem_d = mem_d;
            end
            cnt_d = CNT_W'(int'(cnt_q) + (push_i ? 1 : 0) - (do_pop_s ? 1 : 0));
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[0];
    assign valid_o = (cnt_q != '0);

endmodule

// File: rtl/msrv_32_fetch_unit.sv
// AHB-Lite instruction fetch stage: owns the PC, issues reads, buffers words for decode.
// Define MSRV32_FETCH_PIPELINE_EN to overlap the next address phase with the current data phase.
module msrv_32_fetch_unit
    import msrv_32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] pc_mux_in,
    input  logic        redirect_in,
    input  logic        misaligned_in,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in,
    input  logic        instr_ready_in,
    output logic [31:0] iaddr_out,
    output logic [1:0]  htrans_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        instr_valid_out,
    output logic        bus_err_out,
    output logic        misaligned_out
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
`ifdef MSRV32_FETCH_PIPELINE_EN
    localparam int DISC_W = 2;
`else
    localparam int DISC_W = 1;
`endif

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;
    logic [DISC_W-1:0] discard_q, discard_d;

    logic              issue_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic [CNT_W-1:0]  count_s;
    buf_entry_t        head_s;
    buf_entry_t        push_data_s;
    logic              head_valid_s;

    assign pop_s       = head_valid_s && instr_ready_in;
    assign push_data_s = '{instr: hrdata_in, pc: req_pc_q};

    // Address-phase issue; redirect, sticky flags and reset all force IDLE.
    always_comb begin
        issue_s = 1'b0;
        if (rst_n_in && !redirect_in && !err_q && !mis_q) begin
            if (state_q == ST_REQ) begin
                issue_s = (int'(count_s) < BUF_DEPTH);
`ifdef MSRV32_FETCH_PIPELINE_EN
            end else if (state_q == ST_DATA) begin
                issue_s = !hresp_in && ((int'(count_s) + 1 < BUF_DEPTH) || pop_s);
`endif
            end else begin
                issue_s = 1'b0;
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    assign accept_s   = issue_s && hready_in;
    assign htrans_out = issue_s ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign iaddr_out  = pc_q;

    // Next-state logic; redirect has priority over every state action.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        err_d     = err_q;
        mis_d     = mis_q;
        discard_d = discard_q;
        push_s    = 1'b0;
        flush_s   = 1'b0;
        if (redirect_in) begin
            pc_d    = pc_mux_in;
            err_d   = 1'b0;
            mis_d   = misaligned_in;
            flush_s = 1'b1;
            if ((state_q == ST_DATA) && !hready_in) begin
                // The beat still in flight must be swallowed when it returns.
                discard_d = DISC_W'(1);
                state_d   = ST_DATA;
            end else begin
                discard_d = '0;
                state_d   = misaligned_in ? ST_ERR : ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (accept_s) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_mux_in;
                        state_d  = ST_DATA;
                    end else begin
                        state_d  = ST_REQ;
                    end
                end
                ST_DATA: begin
                    if (hready_in) begin
                        discard_d = '0;
                        if (discard_q != '0) begin
                            state_d = mis_q ? ST_ERR : ST_REQ;
                        end else if (hresp_in) begin
                            err_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            push_s  = 1'b1;
                            state_d = ST_REQ;
                        end
`ifdef MSRV32_FETCH_PIPELINE_EN
                        if (accept_s) begin
                            req_pc_d = pc_q;
                            pc_d     = pc_mux_in;
                            state_d  = ST_DATA;
                        end else begin
                            req_pc_d = req_pc_q;
                        end
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // Fetch state, PC and sticky status registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_REQ;
            pc_q      <= BOOT_ADDR;
            req_pc_q  <= 32'h0000_0000;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
            discard_q <= discard_d;
        end
    end

    msrv_32_instr_buf #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_instr_buf (
        .clk_i       (clk_in),
        .rst_n_i     (rst_n_in),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (flush_s),
        .count_o     (count_s),
        .head_o      (head_s),
        .valid_o     (head_valid_s)
    );

    assign pc_out          = pc_q;
    assign instr_out       = head_s.instr;
    assign instr_pc_out    = head_s.pc;
    assign instr_valid_out = head_valid_s;
    assign bus_err_out     = err_q;
    assign misaligned_out  = mis_q;

endmodule
